// File: rtl/ctrl_pkg.sv
// Shared constants for the controller input-conditioning path: channel map,
// default pin polarity and debounce period.
package ctrl_pkg;

    localparam int unsigned N_IN = 6;

    localparam int unsigned CH_LEFT   = 0;
    localparam int unsigned CH_RIGHT  = 1;
    localparam int unsigned CH_UP     = 2;
    localparam int unsigned CH_DOWN   = 3;
    localparam int unsigned CH_ATTACK = 4;
    localparam int unsigned CH_PERY   = 5;

    // 1 = raw pin is active-low (directional pad pulls low when pressed)
    localparam logic [N_IN-1:0] ACTIVE_LOW_MASK_DEFAULT = 6'b001111;

    // 10 ms at 100 MHz
    localparam int unsigned DEBOUNCE_CYCLES_10MS = 1000000;

    // Counter width able to hold 0..cycles-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles > 2) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One controller line: two-flop synchroniser with polarity fix, stability
// counter, and registered press/release pulses on accepted transitions.
module debounce_channel
    import ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_10MS,
    parameter logic        ACTIVE_LOW      = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press,
    output logic rel
);

    localparam int unsigned         CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             level_nxt;
    logic             press_nxt;
    logic             rel_nxt;

    // Count consecutive cycles the synchronised value disagrees with the level.
    always_comb begin
        cnt_nxt   = '0;
        level_nxt = level;
        press_nxt = 1'b0;
        rel_nxt   = 1'b0;
        if (s2 != level) begin
            if (cnt == CNT_LAST) begin
                level_nxt = s2;
                press_nxt = s2;
                rel_nxt   = ~s2;
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
            rel   <= 1'b0;
        end else begin
            s1    <= raw ^ ACTIVE_LOW;
            s2    <= s1;
            cnt   <= cnt_nxt;
            level <= level_nxt;
            press <= press_nxt;
            rel   <= rel_nxt;
        end
    end

endmodule

// File: rtl/controller_debounce.sv
// Pmod controller input conditioning: one independent debounce channel per
// raw pin, producing active-high levels and one-cycle edge pulses.
module controller_debounce
    import ctrl_pkg::*;
#(
    parameter int unsigned     DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_10MS,
    parameter logic [N_IN-1:0] ACTIVE_LOW_MASK = ACTIVE_LOW_MASK_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_IN-1:0] raw_in,
    output logic [N_IN-1:0] btn_level,
    output logic [N_IN-1:0] btn_press,
    output logic [N_IN-1:0] btn_release
);

    for (genvar i = 0; i < N_IN; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW_MASK[i])
        ) u_ch (
            .clk   (clk),
            .reset (reset),
            .raw   (raw_in[i]),
            .level (btn_level[i]),
            .press (btn_press[i]),
            .rel   (btn_release[i])
        );
    end

endmodule
